// File: rtl/alu_pkg.sv
// Shared opcode encodings and CDB packet type for the pipelined integer functional unit.
package alu_pkg;

    localparam int unsigned ALU_XLEN  = 32;
    localparam int unsigned ALU_TAG_W = 7;
    localparam int unsigned ALU_OP_W  = 6;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 6'b011011;
    localparam alu_op_t OP_SUB  = 6'b011100;
    localparam alu_op_t OP_SLL  = 6'b011101;
    localparam alu_op_t OP_SLT  = 6'b011110;
    localparam alu_op_t OP_SLTU = 6'b011111;
    localparam alu_op_t OP_XOR  = 6'b100000;
    localparam alu_op_t OP_SRL  = 6'b100001;
    localparam alu_op_t OP_SRA  = 6'b100010;
    localparam alu_op_t OP_OR   = 6'b100011;
    localparam alu_op_t OP_AND  = 6'b100100;
    localparam alu_op_t OP_MUL  = 6'b100101;

    typedef struct packed {
        logic [ALU_TAG_W-1:0] tag;
        logic [ALU_XLEN-1:0]  value;
    } cdb_pkt_t;

endpackage

// File: rtl/alu_compute.sv
// Combinational integer datapath: (op, src1, src2) -> result. Undefined opcodes yield 0.
// Define ALU_MUL_EN to add OP_MUL (low XLEN bits of the unsigned product).
module alu_compute
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = ALU_XLEN,
    parameter int unsigned OP_W = ALU_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = src2[SH_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = src1 + src2;
            OP_SUB:  result = src1 - src2;
            OP_SLL:  result = src1 << shamt;
            OP_SLT:  result = XLEN'($signed(src1) < $signed(src2));
            OP_SLTU: result = XLEN'(src1 < src2);
            OP_XOR:  result = src1 ^ src2;
            OP_SRL:  result = src1 >> shamt;
            OP_SRA:  result = $unsigned($signed(src1) >>> shamt);
            OP_OR:   result = src1 | src2;
            OP_AND:  result = src1 & src2;
`ifdef ALU_MUL_EN
            OP_MUL:  result = src1 * src2;
`else
            OP_MUL:  result = '0;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_funit_pipe.sv
// Pipelined integer functional unit: valid/ready issue, LAT-cycle execute, in-order
// completion FIFO broadcast on the CDB under req/grant, with flush on mispredict.
module alu_funit_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = ALU_XLEN,
    parameter int unsigned TAG_W      = ALU_TAG_W,
    parameter int unsigned OP_W       = ALU_OP_W,
    parameter int unsigned LAT        = 1,
    parameter int unsigned OUTQ_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [XLEN-1:0]  issue_src1,
    input  logic [XLEN-1:0]  issue_src2,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value
);

    localparam int unsigned PTR_W = (OUTQ_DEPTH > 1) ? $clog2(OUTQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUTQ_DEPTH + 1);

    logic             accept;
    logic             pop;
    logic [XLEN-1:0]  alu_result;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [XLEN-1:0]  wr_value;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] q_cnt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [TAG_W-1:0] q_tag   [OUTQ_DEPTH];
    logic [XLEN-1:0]  q_value [OUTQ_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    alu_compute #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_compute (
        .op     (issue_op),
        .src1   (issue_src1),
        .src2   (issue_src2),
        .result (alu_result)
    );

    // occ counts pipe plus queue, so a full credit count can still accept when the head pops.
    assign cdb_req     = !reset && (q_cnt != '0);
    assign pop         = cdb_req && cdb_grant;
    assign issue_ready = !reset && ((occ < CNT_W'(OUTQ_DEPTH)) || pop);
    assign accept      = issue_valid && issue_ready && !flush;
    assign cdb_tag     = cdb_req ? q_tag[head]   : '0;
    assign cdb_value   = cdb_req ? q_value[head] : '0;

    // The queue write itself is the last of the LAT stages.
    if (LAT == 1) begin : g_direct
        assign wr_valid = accept;
        assign wr_tag   = issue_tag;
        assign wr_value = alu_result;
    end else begin : g_pipe
        logic             p_valid [LAT-1];
        logic [TAG_W-1:0] p_tag   [LAT-1];
        logic [XLEN-1:0]  p_value [LAT-1];

        always_ff @(posedge clock) begin
            if (reset || flush) begin
                for (int unsigned i = 0; i < LAT - 1; i++) begin
                    p_valid[i] <= 1'b0;
                end
            end else begin
                p_valid[0] <= accept;
                for (int unsigned i = 1; i < LAT - 1; i++) begin
                    p_valid[i] <= p_valid[i-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            p_tag[0]   <= issue_tag;
            p_value[0] <= alu_result;
            for (int unsigned i = 1; i < LAT - 1; i++) begin
                p_tag[i]   <= p_tag[i-1];
                p_value[i] <= p_value[i-1];
            end
        end

        assign wr_valid = p_valid[LAT-2];
        assign wr_tag   = p_tag[LAT-2];
        assign wr_value = p_value[LAT-2];
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            q_cnt <= '0;
            occ   <= '0;
        end else begin
            if (wr_valid) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            q_cnt <= q_cnt + CNT_W'(wr_valid) - CNT_W'(pop);
            occ   <= occ + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_valid) begin
            q_tag[tail]   <= wr_tag;
            q_value[tail] <= wr_value;
        end
    end

endmodule

// File: tb/tb_alu_funit_pipe.sv
// Self-checking bench for alu_funit_pipe (LAT=2, OUTQ_DEPTH=3) against an in-order
// queue model with per-entry visibility cycle; directed cases followed by random traffic.
module tb_alu_funit_pipe;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_op;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [6:0]  issue_tag;
    logic        cdb_req;
    logic        cdb_grant;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_value;

    always #5 clock = ~clock;

    alu_funit_pipe #(
        .XLEN       (32),
        .TAG_W      (7),
        .OP_W       (6),
        .LAT        (LAT),
        .OUTQ_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_src1  (issue_src1),
        .issue_src2  (issue_src2),
        .issue_tag   (issue_tag),
        .cdb_req     (cdb_req),
        .cdb_grant   (cdb_grant),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value)
    );

    typedef struct {
        logic [6:0]  tag;
        logic [31:0] value;
        int          due;
    } item_t;

    item_t mq[$];
    int    cyc    = 0;
    int    n_vec  = 0;
    int    n_err  = 0;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            6'b011011: return a + b;
            6'b011100: return a - b;
            6'b011101: return a << s;
            6'b011110: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'b011111: return (a < b) ? 32'd1 : 32'd0;
            6'b100000: return a ^ b;
            6'b100001: return a >> s;
            6'b100010: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            6'b100011: return a | b;
            6'b100100: return a & b;
`ifdef ALU_MUL_EN
            6'b100101: return a * b;
`endif
            default:   return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic cycle(input bit v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [6:0] tag, input bit g,
                         input bit f, input bit rst, output bit acc);
        bit exp_req;
        bit exp_rdy;
        item_t it;
        @(negedge clock);
        reset       = rst;
        flush       = f;
        issue_valid = v;
        issue_op    = op;
        issue_src1  = a;
        issue_src2  = b;
        issue_tag   = tag;
        cdb_grant   = g;
        #1;
        exp_req = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        exp_rdy = !rst && ((mq.size() < DEPTH) || (exp_req && g));
        chk("cdb_req", {31'b0, cdb_req}, {31'b0, exp_req});
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_rdy});
        if (exp_req) begin
            chk("cdb_tag", {25'b0, cdb_tag}, {25'b0, mq[0].tag});
            chk("cdb_value", cdb_value, mq[0].value);
        end
        if (rst) begin
            chk("reset_tag", {25'b0, cdb_tag}, 32'h0);
            chk("reset_value", cdb_value, 32'h0);
        end
        acc = v && exp_rdy && !f && !rst;
        @(posedge clock);
        if (rst || f) begin
            mq.delete();
        end else begin
            if (exp_req && g) void'(mq.pop_front());
            if (acc) begin
                it.tag   = tag;
                it.value = ref_alu(op, a, b);
                it.due   = cyc + LAT;
                mq.push_back(it);
            end
        end
        cyc++;
    endtask

    task automatic idle(input bit g);
        bit acc;
        cycle(1'b0, 6'h0, 32'h0, 32'h0, 7'h0, g, 1'b0, 1'b0, acc);
    endtask

    logic [5:0] op_tab [11];

    initial begin
        bit          acc;
        int          k;
        logic [5:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        op_tab[0]  = 6'b011011; op_tab[1]  = 6'b011100; op_tab[2]  = 6'b011101;
        op_tab[3]  = 6'b011110; op_tab[4]  = 6'b011111; op_tab[5]  = 6'b100000;
        op_tab[6]  = 6'b100001; op_tab[7]  = 6'b100010; op_tab[8]  = 6'b100011;
        op_tab[9]  = 6'b100100; op_tab[10] = 6'b100101;

        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_src1 = '0; issue_src2 = '0; issue_tag = '0; cdb_grant = 1'b0;

        // reset hold, with an issue attempt that must be refused
        repeat (2) cycle(1'b0, 6'h0, 32'h0, 32'h0, 7'h0, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 6'b011011, 32'd1, 32'd1, 7'd1, 1'b1, 1'b0, 1'b1, acc);

        // ADD 5+7 tag 3
        cycle(1'b1, 6'b011011, 32'd5, 32'd7, 7'd3, 1'b1, 1'b0, 1'b0, acc);
        repeat (3) idle(1'b1);

        // back-to-back SUB / SRA / SLTU with grant held
        cycle(1'b1, 6'b011100, 32'h0, 32'h1, 7'd10, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b100010, 32'h8000_0000, 32'd4, 7'd11, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011111, 32'h1, 32'hFFFF_FFFF, 7'd12, 1'b1, 1'b0, 1'b0, acc);
        repeat (4) idle(1'b1);

        // grant withheld: queue fills, ready drops, then accept+pop in the same cycle
        k = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(k < 4, 6'b100000, 32'h1111 * k, 32'hF0F0, 7'(20 + k), 1'b0, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("held_accepts", k, DEPTH);
        for (int c = 0; c < 12; c++) begin
            cycle(k < 4, 6'b100000, 32'h1111 * k, 32'hF0F0, 7'(20 + k), 1'b1, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("all_accepted", k, 4);

        // flush with two queued and one in the pipe; flush-cycle issue is dropped
        cycle(1'b1, 6'b011011, 32'd1, 32'd2, 7'd40, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011011, 32'd3, 32'd4, 7'd41, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011011, 32'd5, 32'd6, 7'd42, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011011, 32'd7, 32'd8, 7'd43, 1'b1, 1'b1, 1'b0, acc);
        repeat (4) idle(1'b1);

        // MUL opcode and a fully undefined opcode
        cycle(1'b1, 6'b100101, 32'd3, 32'd4, 7'd50, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b111111, 32'd9, 32'd9, 7'd51, 1'b1, 1'b0, 1'b0, acc);
        repeat (4) idle(1'b1);

        // reset mid-operation
        cycle(1'b1, 6'b011101, 32'h1, 32'd31, 7'd60, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011110, 32'hFFFF_FFFF, 32'd1, 7'd61, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'b011011, 32'd1, 32'd1, 7'd62, 1'b0, 1'b0, 1'b1, acc);
        repeat (3) idle(1'b1);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else rop = op_tab[$urandom_range(0, 10)];
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            cycle($urandom_range(0, 3) != 0, rop, ra, rb, 7'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 33) == 0,
                  $urandom_range(0, 59) == 0, acc);
        end
        repeat (6) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
